// File: rtl/mux_stream.sv
// Registered N-to-1 stream multiplexer with fixed-select or round-robin arbitration.
// Define MUX_STREAM_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module mux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef MUX_STREAM_PKT_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SELW-1:0]           out_chan
);

    localparam int NSEL = 1 << SELW;

    // Channel views padded to the full sel range so any index is in bounds.
    logic [WIDTH-1:0] ch_data [NSEL];
    logic [NSEL-1:0]  ch_valid;
`ifdef MUX_STREAM_PKT_LOCK_EN
    logic [NSEL-1:0]  ch_last;
`endif

    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_chan
            if (gi < CHANNELS) begin : g_real
                assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
                assign ch_valid[gi] = in_valid[gi];
`ifdef MUX_STREAM_PKT_LOCK_EN
                assign ch_last[gi]  = in_last[gi];
`endif
            end else begin : g_pad
                assign ch_data[gi]  = '0;
                assign ch_valid[gi] = 1'b0;
`ifdef MUX_STREAM_PKT_LOCK_EN
                assign ch_last[gi]  = 1'b0;
`endif
            end
        end
    endgenerate

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic [SELW:0]    rr_sum;
    logic             grant_ok;
    logic [SELW-1:0]  grant_idx;
    logic             can_load;
    logic             load_en;
    logic             accept;
    logic             beat_last;

`ifdef MUX_STREAM_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t     state_q, state_d;
    logic [SELW-1:0] lock_chan_q, lock_chan_d;
    logic            out_last_q, out_last_d;
`endif

    // Round-robin search: first valid channel at or after ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rr_sum = {1'b0, ptr_q} + (SELW+1)'(i);
            if (rr_sum >= (SELW+1)'(CHANNELS)) begin
                rr_sum = rr_sum - (SELW+1)'(CHANNELS);
            end
            if (!rr_found && ch_valid[rr_sum[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[SELW-1:0];
            end
        end
    end

    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        if (mode) begin
            grant_ok  = rr_found;
            grant_idx = rr_idx;
        end else if ({1'b0, sel} < (SELW+1)'(CHANNELS)) begin
            grant_ok  = 1'b1;
            grant_idx = sel;
        end
`ifdef MUX_STREAM_PKT_LOCK_EN
        if (state_q == ST_LOCKED) begin
            grant_ok  = 1'b1;
            grant_idx = lock_chan_q;
        end
`endif
    end

    assign can_load = !out_valid_q || out_ready;
    assign load_en  = grant_ok && can_load && !rst;
    assign accept   = load_en && ch_valid[grant_idx];

`ifdef MUX_STREAM_PKT_LOCK_EN
    assign beat_last = ch_last[grant_idx];
`else
    assign beat_last = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign in_ready[gi] = load_en && (grant_idx == SELW'(gi));
        end
    endgenerate

    // Output register and arbitration pointer; a load and an unload on the same edge reloads.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_data_d  = ch_data[grant_idx];
            out_valid_d = 1'b1;
            out_chan_d  = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept && mode && beat_last) begin
            if ({1'b0, grant_idx} + (SELW+1)'(1) >= (SELW+1)'(CHANNELS)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SELW'(1);
            end
        end
    end

`ifdef MUX_STREAM_PKT_LOCK_EN
    always_comb begin
        state_d     = state_q;
        lock_chan_d = lock_chan_q;
        out_last_d  = out_last_q;
        if (accept) begin
            out_last_d = beat_last;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept && !beat_last) begin
                    state_d     = ST_LOCKED;
                    lock_chan_d = grant_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && beat_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_chan_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_chan_q <= lock_chan_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule
